ldpc_3gpp_dec_mem_sched: RTL and testbench

Pass scheduler for the decoder node memory. It generates the read-side control stream (read enable, frame/packet strobes, Hb row/column/zc indices, cnode/vnode mode) that drives the node memory block and its Hb lookup. Each decode iteration is one cnode pass followed by one vnode pass. A programmable drain gap separates passes so that in-flight writes land before the read mode flips.

---
 rtl/ldpc_3gpp_dec_mem_sched.sv | 221 ++++++++++++++++++++++
 tb/tb_ldpc_3gpp_dec_mem_sched.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_3gpp_dec_mem_sched.sv
// Read-side pass scheduler for the LDPC decoder node memory: cnode/vnode passes with drain gaps.
// Optional early stop on syndrome pass: define LDPC_3GPP_DEC_MEM_SCHED_EARLY_STOP_EN.
module ldpc_3gpp_dec_mem_sched #(
  parameter int unsigned pROW_W  = 6,
  parameter int unsigned pCOL_W  = 5,
  parameter int unsigned pZC_W   = 9,
  parameter int unsigned pITER_W = 6,
  parameter int unsigned pDRAIN  = 8
) (
  input  logic               iclk,
  input  logic               ireset_n,
  input  logic               iclkena,
  input  logic               istart,
  input  logic [pROW_W-1:0]  irow_num,
  input  logic [pCOL_W-1:0]  icol_num,
  input  logic [pZC_W-1:0]   iused_zc,
  input  logic [pITER_W-1:0] iiter_num,
  input  logic               isyndrome_ok,
  output logic               obusy,
  output logic               oread,
  output logic               oc_nv_mode,
  output logic               osof,
  output logic               osop,
  output logic               oeop,
  output logic               oeof,
  output logic [pROW_W-1:0]  ohb_row,
  output logic [pCOL_W-1:0]  ohb_col,
  output logic [pZC_W-1:0]   ozc_idx,
  output logic [pITER_W-1:0] oiter,
  output logic               odone
);

  localparam int unsigned DRAIN_W = (pDRAIN > 1) ? $clog2(pDRAIN) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'((pDRAIN > 0) ? pDRAIN - 1 : 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CNODE  = 3'd1;
  localparam logic [2:0] S_CDRAIN = 3'd2;
  localparam logic [2:0] S_VNODE  = 3'd3;
  localparam logic [2:0] S_VDRAIN = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [pROW_W-1:0]  row_q, row_d, cfg_row_q, cfg_row_d;
  logic [pCOL_W-1:0]  col_q, col_d, cfg_col_q, cfg_col_d;
  logic [pZC_W-1:0]   zc_q, zc_d, cfg_zc_q, cfg_zc_d;
  logic [pITER_W-1:0] iter_q, iter_d, cfg_iter_q, cfg_iter_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;

  logic row_last_c, col_last_c, zc_last_c, pass_last_c, iter_last_c, stop_c, cfg_zero_c;

  assign row_last_c  = (row_q == cfg_row_q - pROW_W'(1));
  assign col_last_c  = (col_q == cfg_col_q - pCOL_W'(1));
  assign zc_last_c   = (zc_q == cfg_zc_q - pZC_W'(1));
  assign pass_last_c = row_last_c && col_last_c && zc_last_c;
  assign iter_last_c = (iter_q == cfg_iter_q - pITER_W'(1));
  assign cfg_zero_c  = (irow_num == '0) || (icol_num == '0) || (iused_zc == '0) || (iiter_num == '0);

`ifdef LDPC_3GPP_DEC_MEM_SCHED_EARLY_STOP_EN
  assign stop_c = iter_last_c || isyndrome_ok;
`else
  logic unused_syndrome;
  assign unused_syndrome = isyndrome_ok;
  assign stop_c = iter_last_c;
`endif

  // Next-state and index sequencing; cnode order row/col/zc, vnode order col/zc/row.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    zc_d       = zc_q;
    iter_d     = iter_q;
    drain_d    = drain_q;
    cfg_row_d  = cfg_row_q;
    cfg_col_d  = cfg_col_q;
    cfg_zc_d   = cfg_zc_q;
    cfg_iter_d = cfg_iter_q;
    case (state_q)
      S_IDLE: begin
        if (istart) begin
          cfg_row_d  = irow_num;
          cfg_col_d  = icol_num;
          cfg_zc_d   = iused_zc;
          cfg_iter_d = iiter_num;
          row_d      = '0;
          col_d      = '0;
          zc_d       = '0;
          iter_d     = '0;
          state_d    = cfg_zero_c ? S_DONE : S_CNODE;
        end
      end
      S_CNODE: begin
        if (pass_last_c) begin
          row_d = '0;
          col_d = '0;
          zc_d  = '0;
          if (pDRAIN == 0) begin
            state_d = S_VNODE;
          end else begin
            state_d = S_CDRAIN;
            drain_d = DRAIN_LOAD;
          end
        end else if (!zc_last_c) begin
          zc_d = zc_q + pZC_W'(1);
        end else begin
          zc_d = '0;
          if (!col_last_c) begin
            col_d = col_q + pCOL_W'(1);
          end else begin
            col_d = '0;
            row_d = row_q + pROW_W'(1);
          end
        end
      end
      S_CDRAIN: begin
        if (drain_q == '0) state_d = S_VNODE;
        else               drain_d = drain_q - DRAIN_W'(1);
      end
      S_VNODE: begin
        if (pass_last_c) begin
          row_d = '0;
          col_d = '0;
          zc_d  = '0;
          if (pDRAIN == 0) begin
            state_d = stop_c ? S_DONE : S_CNODE;
            if (!stop_c) iter_d = iter_q + pITER_W'(1);
          end else begin
            state_d = S_VDRAIN;
            drain_d = DRAIN_LOAD;
          end
        end else if (!row_last_c) begin
          row_d = row_q + pROW_W'(1);
        end else begin
          row_d = '0;
          if (!zc_last_c) begin
            zc_d = zc_q + pZC_W'(1);
          end else begin
            zc_d  = '0;
            col_d = col_q + pCOL_W'(1);
          end
        end
      end
      S_VDRAIN: begin
        if (drain_q == '0) begin
          state_d = stop_c ? S_DONE : S_CNODE;
          if (!stop_c) iter_d = iter_q + pITER_W'(1);
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode of the next cycle so every output leaves a flop.
  logic rd_d_c, cmode_d_c, first_d_c, last_d_c, sop_d_c, eop_d_c;
  logic rl_d_c, cl_d_c, zl_d_c;

  assign rl_d_c    = (row_d == cfg_row_d - pROW_W'(1));
  assign cl_d_c    = (col_d == cfg_col_d - pCOL_W'(1));
  assign zl_d_c    = (zc_d == cfg_zc_d - pZC_W'(1));
  assign rd_d_c    = (state_d == S_CNODE) || (state_d == S_VNODE);
  assign cmode_d_c = (state_d != S_VNODE) && (state_d != S_VDRAIN);
  assign first_d_c = (row_d == '0) && (col_d == '0) && (zc_d == '0);
  assign last_d_c  = rl_d_c && cl_d_c && zl_d_c;
  assign sop_d_c   = (state_d == S_CNODE) ? (zc_d == '0) : (row_d == '0);
  assign eop_d_c   = (state_d == S_CNODE) ? zl_d_c : rl_d_c;

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      zc_q       <= '0;
      iter_q     <= '0;
      drain_q    <= '0;
      cfg_row_q  <= '0;
      cfg_col_q  <= '0;
      cfg_zc_q   <= '0;
      cfg_iter_q <= '0;
      obusy      <= 1'b0;
      oread      <= 1'b0;
      oc_nv_mode <= 1'b1;
      osof       <= 1'b0;
      osop       <= 1'b0;
      oeop       <= 1'b0;
      oeof       <= 1'b0;
      ohb_row    <= '0;
      ohb_col    <= '0;
      ozc_idx    <= '0;
      oiter      <= '0;
      odone      <= 1'b0;
    end else if (iclkena) begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      zc_q       <= zc_d;
      iter_q     <= iter_d;
      drain_q    <= drain_d;
      cfg_row_q  <= cfg_row_d;
      cfg_col_q  <= cfg_col_d;
      cfg_zc_q   <= cfg_zc_d;
      cfg_iter_q <= cfg_iter_d;
      obusy      <= (state_d != S_IDLE) && (state_d != S_DONE);
      oread      <= rd_d_c;
      oc_nv_mode <= cmode_d_c;
      osof       <= rd_d_c && first_d_c;
      osop       <= rd_d_c && sop_d_c;
      oeop       <= rd_d_c && eop_d_c;
      oeof       <= rd_d_c && last_d_c;
      ohb_row    <= row_d;
      ohb_col    <= col_d;
      ozc_idx    <= zc_d;
      oiter      <= iter_d;
      odone      <= (state_d == S_DONE);
    end
  end

endmodule

// File: tb/tb_ldpc_3gpp_dec_mem_sched.sv
// Self-checking bench: random configs and clock-enable gating against a loop-nest reference model.
module tb_ldpc_3gpp_dec_mem_sched;

  localparam int unsigned RW = 6;
  localparam int unsigned CW = 5;
  localparam int unsigned ZW = 9;
  localparam int unsigned IW = 6;

  typedef struct packed {
    logic          bs;
    logic          rd;
    logic          md;
    logic          sof;
    logic          sop;
    logic          eop;
    logic          eof;
    logic          dn;
    logic [IW-1:0] it;
    logic [RW-1:0] r;
    logic [CW-1:0] c;
    logic [ZW-1:0] z;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, ena, syn, start8, start0;
  logic [RW-1:0] rows;
  logic [CW-1:0] cols;
  logic [ZW-1:0] zcs;
  logic [IW-1:0] iters;

  logic b8, rd8, md8, sof8, sop8, eop8, eof8, dn8;
  logic b0, rd0, md0, sof0, sop0, eop0, eof0, dn0;
  logic [RW-1:0] r8, r0;
  logic [CW-1:0] c8, c0;
  logic [ZW-1:0] z8, z0;
  logic [IW-1:0] it8, it0;

  ldpc_3gpp_dec_mem_sched #(.pDRAIN(8)) dut (
    .iclk(clk), .ireset_n(rst_n), .iclkena(ena), .istart(start8),
    .irow_num(rows), .icol_num(cols), .iused_zc(zcs), .iiter_num(iters),
    .isyndrome_ok(syn), .obusy(b8), .oread(rd8), .oc_nv_mode(md8),
    .osof(sof8), .osop(sop8), .oeop(eop8), .oeof(eof8),
    .ohb_row(r8), .ohb_col(c8), .ozc_idx(z8), .oiter(it8), .odone(dn8)
  );

  ldpc_3gpp_dec_mem_sched #(.pDRAIN(0)) dut_nodrain (
    .iclk(clk), .ireset_n(rst_n), .iclkena(ena), .istart(start0),
    .irow_num(rows), .icol_num(cols), .iused_zc(zcs), .iiter_num(iters),
    .isyndrome_ok(syn), .obusy(b0), .oread(rd0), .oc_nv_mode(md0),
    .osof(sof0), .osop(sop0), .oeop(eop0), .oeof(eof0),
    .ohb_row(r0), .ohb_col(c0), .ozc_idx(z0), .oiter(it0), .odone(dn0)
  );

  logic sel0;
  rec_t obs;
  always_comb begin
    if (sel0) obs = {b0, rd0, md0, sof0, sop0, eop0, eof0, dn0, it0, r0, c0, z0};
    else      obs = {b8, rd8, md8, sof8, sop8, eop8, eof8, dn8, it8, r8, c8, z8};
  end

  rec_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Expected per-cycle output stream of one decode, straight from the loop nests.
  function automatic void build_model(int R, int C, int Z, int N, int D);
    rec_t e;
    exp_q.delete();
    if (R > 0 && C > 0 && Z > 0) begin
      for (int it = 0; it < N; it++) begin
        for (int r = 0; r < R; r++)
          for (int c = 0; c < C; c++)
            for (int z = 0; z < Z; z++) begin
              e = '0; e.bs = 1; e.rd = 1; e.md = 1; e.it = IW'(it);
              e.r = RW'(r); e.c = CW'(c); e.z = ZW'(z);
              e.sof = (r == 0 && c == 0 && z == 0);
              e.eof = (r == R-1 && c == C-1 && z == Z-1);
              e.sop = (z == 0); e.eop = (z == Z-1);
              exp_q.push_back(e);
            end
        for (int d = 0; d < D; d++) begin
          e = '0; e.bs = 1; e.md = 1; e.it = IW'(it); exp_q.push_back(e);
        end
        for (int c = 0; c < C; c++)
          for (int z = 0; z < Z; z++)
            for (int r = 0; r < R; r++) begin
              e = '0; e.bs = 1; e.rd = 1; e.md = 0; e.it = IW'(it);
              e.r = RW'(r); e.c = CW'(c); e.z = ZW'(z);
              e.sof = (r == 0 && c == 0 && z == 0);
              e.eof = (r == R-1 && c == C-1 && z == Z-1);
              e.sop = (r == 0); e.eop = (r == R-1);
              exp_q.push_back(e);
            end
        for (int d = 0; d < D; d++) begin
          e = '0; e.bs = 1; e.md = 0; e.it = IW'(it); exp_q.push_back(e);
        end
      end
    end
    e = '0; e.md = 1; e.dn = 1;
    e.it = (R > 0 && C > 0 && Z > 0 && N > 0) ? IW'(N-1) : '0;
    exp_q.push_back(e);
  endfunction

  // Runs one decode; Nm is the iteration count the model expects (may differ under early stop).
  task automatic run_case(input string name, input bit s0, input int R, input int C, input int Z,
                          input int N, input int Nm, input bit rnd_ena, input bit syn_hi);
    rec_t expd, om, em;
    int   k = 0;
    int   guard = 0;
    bit   adv = 1'b1;
    build_model(R, C, Z, Nm, s0 ? 0 : 8);
    sel0 = s0;
    @(negedge clk);
    rows = RW'(R); cols = CW'(C); zcs = ZW'(Z); iters = IW'(N); ena = 1'b1;
    if (s0) start0 = 1'b1; else start8 = 1'b1;
    syn = syn_hi;
    @(negedge clk);
    start0 = 1'b0; start8 = 1'b0;
    expd = '0;
    while (k < exp_q.size() && guard < 20000) begin
      if (adv) begin expd = exp_q[k]; k++; end
      om = obs; em = expd;
      if (!em.rd) begin om.r = '0; om.c = '0; om.z = '0; em.r = '0; em.c = '0; em.z = '0; end
      if (em.dn) begin om.bs = 1'b0; em.bs = 1'b0; end
      n_cmp++;
      if (om !== em) begin
        n_err++;
        $display("FAIL %s rec %0d: got %h expected %h", name, k-1, om, em);
      end
      adv = (k >= exp_q.size()) ? 1'b1 : (rnd_ena ? 1'(($urandom % 2)) : 1'b1);
      ena = adv;
      if (k < exp_q.size()) begin
        rows = RW'($urandom); cols = CW'($urandom); zcs = ZW'($urandom); iters = IW'($urandom);
        if (s0) start0 = 1'($urandom % 2); else start8 = 1'($urandom % 2);
`ifdef LDPC_3GPP_DEC_MEM_SCHED_EARLY_STOP_EN
        syn = syn_hi;
`else
        syn = syn_hi | 1'($urandom % 2);
`endif
      end else begin
        start0 = 1'b0; start8 = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    start0 = 1'b0; start8 = 1'b0; syn = 1'b0; ena = 1'b1;
    n_cmp++;
    if (guard >= 20000) begin
      n_err++;
      $display("FAIL %s timeout: got %0d records expected %0d", name, k, exp_q.size());
    end else if (obs.rd !== 1'b0 || obs.dn !== 1'b0 || obs.bs !== 1'b0 || obs.md !== 1'b1) begin
      n_err++;
      $display("FAIL %s idle_after_done: got rd=%b dn=%b bs=%b md=%b expected 0 0 0 1",
               name, obs.rd, obs.dn, obs.bs, obs.md);
    end
  endtask

  task automatic test_reset();
    rec_t rst_e;
    rst_e = '0; rst_e.md = 1'b1;
    rst_n = 1'b0;
    #12;
    sel0 = 1'b0; #1;
    n_cmp++;
    if (obs !== rst_e) begin n_err++; $display("FAIL reset_drain8: got %h expected %h", obs, rst_e); end
    sel0 = 1'b1; #1;
    n_cmp++;
    if (obs !== rst_e) begin n_err++; $display("FAIL reset_nodrain: got %h expected %h", obs, rst_e); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_spec_config();
    run_case("cfg_2x3x4_it1", 1'b0, 2, 3, 4, 1, 1, 1'b0, 1'b0);
    run_case("cfg_1x1x1_it3_nodrain", 1'b1, 1, 1, 1, 3, 3, 1'b0, 1'b0);
  endtask

  task automatic test_clkena_gating();
    run_case("cfg_2x3x4_clkena", 1'b0, 2, 3, 4, 1, 1, 1'b1, 1'b0);
    run_case("cfg_1x1x1_clkena", 1'b1, 1, 1, 1, 3, 3, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    int R, C, Z, N;
    for (int i = 0; i < 8; i++) begin
      R = int'($urandom_range(1, 3)); C = int'($urandom_range(1, 3));
      Z = int'($urandom_range(1, 5)); N = int'($urandom_range(1, 3));
      run_case($sformatf("rand%0d", i), 1'(i % 2), R, C, Z, N, N, 1'(($urandom % 2)), 1'b0);
    end
  endtask

  task automatic test_reset_mid_pass();
    rec_t rst_e;
    rst_e = '0; rst_e.md = 1'b1;
    sel0 = 1'b0;
    @(negedge clk);
    rows = 2; cols = 3; zcs = 4; iters = 1; ena = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (obs.rd !== 1'b1) begin n_err++; $display("FAIL mid_pass_reading: got rd=%b expected 1", obs.rd); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== rst_e) begin n_err++; $display("FAIL async_reset_mid_pass: got %h expected %h", obs, rst_e); end
    @(negedge clk);
    rst_n = 1'b1;
    run_case("zero_iter_after_reset", 1'b0, 2, 3, 4, 0, 0, 1'b0, 1'b0);
    run_case("zero_zc_nodrain", 1'b1, 2, 3, 0, 2, 2, 1'b1, 1'b0);
  endtask

  task automatic test_early_stop();
`ifdef LDPC_3GPP_DEC_MEM_SCHED_EARLY_STOP_EN
    run_case("early_stop_on", 1'b0, 2, 2, 2, 5, 1, 1'b0, 1'b1);
`else
    run_case("early_stop_off", 1'b0, 2, 2, 2, 5, 5, 1'b0, 1'b1);
`endif
  endtask

  initial begin
    ena = 1'b1; syn = 1'b0; start8 = 1'b0; start0 = 1'b0; sel0 = 1'b0;
    rows = '0; cols = '0; zcs = '0; iters = '0;
    test_reset();
    test_spec_config();
    test_clkena_gating();
    test_random();
    test_reset_mid_pass();
    test_early_stop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
